// File: rtl/csc_pkg.sv
// Shared types and constants for the RGB->YCbCr (BT.601) sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: channel / FSM state enums, in-flight tag struct, Q9 coefficient table helpers.
package csc_pkg;

  localparam int PIX_W  = 24;
  localparam int COMP_W = 8;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ch_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_Y,
    S_CB,
    S_CR
  } state_e;

  // One entry of the in-flight tag pipe.
  typedef struct packed {
    logic vld;
    ch_e  ch;
  } tag_t;

  // Q9 coefficients, comp: 0=R, 1=G, 2=B.
  function automatic int coef_of(input ch_e ch, input int comp);
    int k;
    k = 0;
    case (ch)
      CH_Y:    k = (comp == 0) ? 153 : (comp == 1) ? 301 : 58;
      CH_CB:   k = (comp == 0) ? -86 : (comp == 1) ? -170 : 256;
      CH_CR:   k = (comp == 0) ? 256 : (comp == 1) ? -214 : -42;
      default: k = 0;
    endcase
    return k;
  endfunction

  // Additive constant per channel.
  function automatic int const_of(input ch_e ch);
    return (ch == CH_Y) ? 0 : 128;
  endfunction

endpackage

// File: rtl/csc_sequencer_if.sv
// Bundles the pixel-in stream, the shared datapath port and the pixel-out stream.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes; datapath has none.
// Modports: master = sequencer side, slave = source/datapath/sink side.
interface csc_sequencer_if #(
  parameter int COEF_W = 18,
  parameter int RES_W  = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic [23:0]              in_rgb;
  logic                     dp_valid;
  logic [23:0]              dp_pix;
  logic signed [COEF_W-1:0] dp_coef_r;
  logic signed [COEF_W-1:0] dp_coef_g;
  logic signed [COEF_W-1:0] dp_coef_b;
  logic signed [RES_W-1:0]  dp_c;
  logic signed [RES_W-1:0]  dp_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [23:0]              out_ycbcr;

  modport master (
    input  in_valid, in_rgb, dp_result, out_ready,
    output in_ready, dp_valid, dp_pix, dp_coef_r, dp_coef_g, dp_coef_b, dp_c,
           out_valid, out_ycbcr
  );

  modport slave (
    output in_valid, in_rgb, dp_result, out_ready,
    input  in_ready, dp_valid, dp_pix, dp_coef_r, dp_coef_g, dp_coef_b, dp_c,
           out_valid, out_ycbcr
  );
endinterface

// File: rtl/csc_out_fifo.sv
// 2-entry synchronous FIFO holding assembled YCbCr pixels.
// Latency: push visible on pop_dat/!empty the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty (upstream credits prevent both).
// Ports: clk, rst_n, push/push_dat, pop, pop_dat (head), full, empty.
module csc_out_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/csc_sequencer.sv
// RGB->YCbCr sequencer: one shared 3-multiply datapath issued Y, Cb, Cr on consecutive cycles.
// Latency: accept at cycle 0 -> out_valid at cycle DP_LAT+4; peak 1 pixel per 3 cycles.
// Backpressure: in_ready needs a free credit (2 total, returned on output pop), so the FIFO never overflows.
// Ports: clk, rst_n, bus (csc_sequencer_if.master: in/dp/out streams), busy.
// Option: define CSC_SATURATE_EN to clamp negative datapath results to 0 instead of wrapping.
import csc_pkg::*;

module csc_sequencer #(
  parameter int DP_LAT = 4,
  parameter int COEF_W = 18,
  parameter int RES_W  = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  csc_sequencer_if.master bus,
  output logic            busy
);
  state_e            state;
  state_e            state_nxt;
  ch_e               cur_ch;
  logic              issue;
  logic              ready_en;
  logic              accept;
  logic              pop;
  logic [1:0]        credits;
  logic [PIX_W-1:0]  pix_q;
  tag_t              tag_q [DP_LAT];
  tag_t              tag_out;
  logic              tags_busy;
  logic [COMP_W-1:0] cap;
  logic [COMP_W-1:0] y_q;
  logic [COMP_W-1:0] cb_q;
  logic              fifo_push;
  logic [PIX_W-1:0]  fifo_dat;
  logic              fifo_full;
  logic              fifo_empty;

  // ready_en holds in_ready low until the first clock after reset release.
  // The !fifo_full term is redundant with the credit count but keeps the FIFO safe on its own.
  assign bus.in_ready = ready_en && ((state == S_IDLE) || (state == S_CR)) &&
                        (credits != 2'd0) && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.dp_pix   = pix_q;
  assign bus.dp_valid = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
      credits  <= 2'd2;
      pix_q    <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        pix_q <= bus.in_rgb;
      end
      case ({accept, pop})
        2'b10:   credits <= credits - 2'd1;
        2'b01:   credits <= credits + 2'd1;
        default: credits <= credits;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    cur_ch    = CH_Y;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_Y;
      end
      S_Y: begin
        issue     = 1'b1;
        cur_ch    = CH_Y;
        state_nxt = S_CB;
      end
      S_CB: begin
        issue     = 1'b1;
        cur_ch    = CH_CB;
        state_nxt = S_CR;
      end
      S_CR: begin
        issue     = 1'b1;
        cur_ch    = CH_CR;
        state_nxt = accept ? S_Y : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Coefficients are only driven while an op is issued; zero otherwise.
  always_comb begin
    bus.dp_coef_r = '0;
    bus.dp_coef_g = '0;
    bus.dp_coef_b = '0;
    bus.dp_c      = '0;
    if (issue) begin
      bus.dp_coef_r = COEF_W'(coef_of(cur_ch, 0));
      bus.dp_coef_g = COEF_W'(coef_of(cur_ch, 1));
      bus.dp_coef_b = COEF_W'(coef_of(cur_ch, 2));
      bus.dp_c      = RES_W'(const_of(cur_ch));
    end
  end

  // Tag pipe mirrors the datapath depth; the last stage lines up with dp_result.
  // Clearing it on reset is what makes late results from before the reset harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: issue, ch: cur_ch};
      for (int i = 1; i < DP_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[DP_LAT-1];

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < DP_LAT; i++) tags_busy = tags_busy | tag_q[i].vld;
  end

`ifdef CSC_SATURATE_EN
  assign cap = bus.dp_result[RES_W-1] ? 8'h00 : 8'(bus.dp_result);
`else
  assign cap = 8'(bus.dp_result);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      cb_q <= '0;
    end else if (tag_out.vld) begin
      if (tag_out.ch == CH_Y)  y_q  <= cap;
      if (tag_out.ch == CH_CB) cb_q <= cap;
    end
  end

  // Cr is the last channel of a pixel, so its capture completes the pixel.
  assign fifo_push = tag_out.vld && (tag_out.ch == CH_CR);

  csc_out_fifo #(.W(PIX_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat ({y_q, cb_q, cap}),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_ycbcr = fifo_dat;
  assign busy          = (state != S_IDLE) || tags_busy || !fifo_empty;

endmodule
